// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and size constants for the memory responder
//
// Contents:
//   DEF_WORD_W / DEF_OP_W  default datapath and opcode field widths
//   DEF_ADDR_W             address width = operand field width
//   DEF_DEPTH              number of stored words
//   state_t                responder FSM states
package mem_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_ADDR_W = DEF_WORD_W - DEF_OP_W;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x WORD_W store, one sync write port, one sync read port
//
// Ports:
//   clock    in   rising-edge clock
//   we       in   write enable
//   waddr    in   write address
//   wd       in   write data
//   re       in   read enable; rd updates only when set
//   raddr    in   read address
//   rd       out  registered read data, holds between reads
// The storage and the read register are deliberately not reset so that
// contents survive a CPU reset.
module mem_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rd
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wd;
    end
    if (re) begin
      rd <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory-bus responder with host stream loader
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   CS          in   chip select from the sequencer
//   R_NW        in   1 = read, 0 = write (while CS=1)
//   addr        in   word address from the MAR
//   wdata       in   write data from the MDR
//   rdata       out  read data, valid the cycle after a read is sampled
//   rvalid      out  one-cycle pulse when rdata was updated by a read
//   ld_start    in   request a full-array load (ignored unless idle, CS=0)
//   ld_valid    in   loader beat strobe
//   ld_data     in   loader beat data
//   ld_busy     out  load in progress; CPU accesses are refused
//   ld_done     out  one-cycle pulse after the final load beat
//   access_err  out  one-cycle pulse after a refused CPU access
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int ADDR_W = WORD_W - OP_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              CS,
  input  logic              R_NW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              access_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic              rvalid_q, ld_done_q, access_err_q;
  logic              done_d, err_d;
  // Set by the first read after reset; gates the unreset array read
  // register so rdata reads 0 out of reset and holds afterwards.
  logic              rd_seen_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wd;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ld_addr_q    <= '0;
      rvalid_q     <= 1'b0;
      ld_done_q    <= 1'b0;
      access_err_q <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_addr_q    <= ld_addr_d;
      rvalid_q     <= mem_re;
      ld_done_q    <= done_d;
      access_err_q <= err_d;
      if (mem_re) begin
        rd_seen_q <= 1'b1;
      end
    end
  end

  // Next state plus the write-port mux: the CPU owns the port in IDLE,
  // the loader owns it in LOAD.
  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wd    = wdata;
    mem_re    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CS) begin
          // A CPU access wins over a simultaneous ld_start, which is dropped.
          if (R_NW) begin
            mem_re = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end else if (ld_start) begin
          state_d   = LOAD;
          ld_addr_d = '0;
        end
      end
      LOAD: begin
        if (CS) begin
          err_d = 1'b1;
        end
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr_q;
          mem_wd    = ld_data;
          ld_addr_d = ld_addr_q + ADDR_W'(1);
          if (ld_addr_q == LAST_ADDR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  mem_array #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wd   (mem_wd),
    .re   (mem_re),
    .raddr(addr),
    .rd   (mem_rd)
  );

  assign rdata      = rd_seen_q ? mem_rd : '0;
  assign rvalid     = rvalid_q;
  assign ld_busy    = (state_q == LOAD);
  assign ld_done    = ld_done_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       CS = 1'b0;
  logic       R_NW = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_busy;
  logic       ld_done;
  logic       access_err;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  mem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .CS        (CS),
    .R_NW      (R_NW),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .access_err(access_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest queued read.
  always @(negedge clock) begin
    if (!reset) begin
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rvalid_unexpected: got rdata %0h, expected no rvalid", rdata);
        end else begin
          chk("read_data", 32'(rdata), 32'(exp_q.pop_front()));
        end
      end
      if (ld_done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_read(input logic [4:0] a, input logic [7:0] e);
    CS = 1'b1; R_NW = 1'b1; addr = a;
    exp_q.push_back(e);
    tick();
    CS = 1'b0; R_NW = 1'b0;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    CS = 1'b1; R_NW = 1'b0; addr = a; wdata = d;
    tick();
    CS = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    ld_valid = 1'b1; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("reset_outputs", {rdata, rvalid, ld_busy, ld_done, access_err}, 32'h0);
    reset = 1'b0;
    tick();

    // Write then read
    cpu_write(5'h03, 8'hA5);
    cpu_read(5'h03, 8'hA5);
    tick(); tick(); tick();
    chk("rdata_hold", 32'(rdata), 32'hA5);

    // Full load with gaps, a refused write and an ignored ld_start
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("busy_after_start", 32'(ld_busy), 32'h1);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin CS = 1'b1; R_NW = 1'b0; addr = 5'd2; wdata = 8'hFF; end
      if (i == 20) ld_start = 1'b1;
      beat(8'(i * 3));
      CS = 1'b0; ld_start = 1'b0;
      if (i == 10) begin
        chk("access_err_pulse", 32'(access_err), 32'h1);
        chk("rdata_held_refused", 32'(rdata), 32'hA5);
      end
      if (i == 11) chk("access_err_single", 32'(access_err), 32'h0);
      if (i == 30) chk("busy_before_last", 32'(ld_busy), 32'h1);
      if (i == 31) begin
        chk("done_last_beat", 32'(ld_done), 32'h1);
        chk("busy_low_with_done", 32'(ld_busy), 32'h0);
      end
      if (i == 4 || i == 17) begin tick(); tick(); end
    end
    tick();
    chk("done_once", 32'(done_cnt), 32'd1);
    cpu_read(5'h1F, 8'h5D);
    cpu_read(5'h02, 8'h06);

    // Reset mid-load
    cpu_write(5'd9, 8'h00);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i <= 10; i++) beat(8'(i * 3));
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("busy_on_reset", 32'(ld_busy), 32'h0);
    chk("rdata_on_reset", 32'(rdata), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    tick();
    cpu_read(5'd9, 8'h1B);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 32; i++) beat((i == 0) ? 8'h77 : 8'(i * 3));
    chk("reload_done", 32'(ld_done), 32'h1);
    tick();
    chk("done_twice", 32'(done_cnt), 32'd2);
    cpu_read(5'd0, 8'h77);
    cpu_read(5'd1, 8'h03);

    // Collision: read wins, ld_start dropped
    cpu_write(5'h03, 8'hA5);
    ld_start = 1'b1;
    cpu_read(5'h03, 8'hA5);
    ld_start = 1'b0;
    chk("collision_busy", 32'(ld_busy), 32'h0);
    tick();
    chk("collision_busy_later", 32'(ld_busy), 32'h0);

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
